// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU control codes, forwarding selects,
// the ID/EX register layout and the forwarding-match helpers.
package mips_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;
    localparam int ALU_W = 4;

    // ALU control line values driven onto gin.
    typedef enum logic [ALU_W-1:0] {
        ALU_AND    = 4'b0000,
        ALU_OR     = 4'b0001,
        ALU_ADD    = 4'b0010,
        ALU_SUB    = 4'b0110,
        ALU_SLT    = 4'b0111,
        ALU_BNE    = 4'b1000,
        ALU_BCMP_C = 4'b1001,
        ALU_BCMP_B = 4'b1011,
        ALU_NOR    = 4'b1100,
        ALU_BCMP_A = 4'b1101,
        ALU_BCMP_D = 4'b1110,
        ALU_PASS_A = 4'b1111
    } alu_ctl_e;

    // Where an EX operand comes from.
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_EXM = 2'b01,
        FWD_MWB = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic alusrc;
        logic regdst;
        logic regwrite;
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic branch;
    } ctrl_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  rs_val;
        logic [XLEN-1:0]  rt_val;
        logic [XLEN-1:0]  imm;
        logic [ALU_W-1:0] gin;
        ctrl_t            ctrl;
    } id_ex_t;

    // A bubble is an all-zero register set: not valid, no side effects.
    localparam id_ex_t ID_EX_BUBBLE = '0;

    // A later stage supplies a register only if it writes it and it is not $0.
    function automatic logic fwd_hit(
        input logic             regwrite,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] src
    );
        return regwrite && (rd != '0) && (rd == src);
    endfunction

    // EX/MEM is younger than MEM/WB, so it wins when both match.
    function automatic fwd_sel_e fwd_select(
        input logic             exm_regwrite,
        input logic [REG_W-1:0] exm_rd,
        input logic             mwb_regwrite,
        input logic [REG_W-1:0] mwb_rd,
        input logic [REG_W-1:0] src
    );
        fwd_sel_e sel;
        sel = FWD_REG;
        if (fwd_hit(exm_regwrite, exm_rd, src)) begin
            sel = FWD_EXM;
        end else if (fwd_hit(mwb_regwrite, mwb_rd, src)) begin
            sel = FWD_MWB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// Forwarding unit: picks the source of each EX operand from the two
// EX-stage source register IDs and the write ports of EX/MEM and MEM/WB.
module fwd_unit
    import mips_pkg::*;
(
    input  logic [REG_W-1:0] ex_rs_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic             exm_regwrite_i,
    input  logic [REG_W-1:0] exm_rd_i,
    input  logic             mwb_regwrite_i,
    input  logic [REG_W-1:0] mwb_rd_i,
    output fwd_sel_e         fwd_a_o,
    output fwd_sel_e         fwd_b_o
);

    // Operand A source select.
    always_comb begin
        fwd_a_o = FWD_REG;
        fwd_a_o = fwd_select(exm_regwrite_i, exm_rd_i,
                             mwb_regwrite_i, mwb_rd_i, ex_rs_i);
    end

    // Operand B source select.
    always_comb begin
        fwd_b_o = FWD_REG;
        fwd_b_o = fwd_select(exm_regwrite_i, exm_rd_i,
                             mwb_regwrite_i, mwb_rd_i, ex_rt_i);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush handling
// and operand forwarding into the ALU.
//
// Handshake: ID offers an instruction with id_valid=1. The instruction is
// accepted on a clk edge where id_valid=1, stall=0 and flush=0. While
// stall=1, ID must hold the same instruction and re-present it; a bubble
// enters EX instead. flush=1 discards the offered instruction that cycle.
module id_ex_stage
    import mips_pkg::*;
(
    input  logic             clk,
    input  logic             reset,

    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic [XLEN-1:0]  id_rs_val,
    input  logic [XLEN-1:0]  id_rt_val,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [ALU_W-1:0] id_gin,
    input  logic             id_alusrc,
    input  logic             id_regdst,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_memwrite,
    input  logic             id_memtoreg,
    input  logic             id_branch,

    input  logic             flush,
    input  logic             exm_regwrite,
    input  logic [REG_W-1:0] exm_rd,
    input  logic [XLEN-1:0]  exm_result,
    input  logic             mwb_regwrite,
    input  logic [REG_W-1:0] mwb_rd,
    input  logic [XLEN-1:0]  mwb_result,

    output logic             stall,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic [ALU_W-1:0] alu_gin,
    output logic [XLEN-1:0]  store_data,
    output logic [REG_W-1:0] ex_wr_rd,
    output logic             ex_valid,
    output logic             ex_regwrite,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic             ex_memtoreg,
    output logic             ex_branch
);

    id_ex_t   ex_q;
    id_ex_t   ex_d;
    id_ex_t   id_pkt;
    logic     load_in_ex;
    logic     rs_dep;
    logic     rt_dep;
    fwd_sel_e fwd_a_sel;
    fwd_sel_e fwd_b_sel;
    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;

    // Pack the decoded ID instruction into the register layout.
    always_comb begin
        id_pkt               = ID_EX_BUBBLE;
        id_pkt.valid         = id_valid;
        id_pkt.rs            = id_rs;
        id_pkt.rt            = id_rt;
        id_pkt.rd            = id_rd;
        id_pkt.rs_val        = id_rs_val;
        id_pkt.rt_val        = id_rt_val;
        id_pkt.imm           = id_imm;
        id_pkt.gin           = id_gin;
        id_pkt.ctrl.alusrc   = id_alusrc;
        id_pkt.ctrl.regdst   = id_regdst;
        id_pkt.ctrl.regwrite = id_regwrite;
        id_pkt.ctrl.memread  = id_memread;
        id_pkt.ctrl.memwrite = id_memwrite;
        id_pkt.ctrl.memtoreg = id_memtoreg;
        id_pkt.ctrl.branch   = id_branch;
    end

    // Load-use hazard: a load in EX whose destination the ID instruction
    // reads. rt only counts when it is a real register operand (alusrc=0)
    // or the store data of a store.
    always_comb begin
        load_in_ex = ex_q.valid && ex_q.ctrl.memread && (ex_q.rt != '0);
        rs_dep     = (ex_q.rt == id_rs);
        rt_dep     = (ex_q.rt == id_rt) && (!id_alusrc || id_memwrite);
        stall      = id_valid && load_in_ex && (rs_dep || rt_dep);
    end

    // Next register contents: flush and stall both insert a bubble.
    always_comb begin
        ex_d = id_pkt;
        if (flush || stall) begin
            ex_d = ID_EX_BUBBLE;
        end
    end

    // ID/EX register; reset clears everything and outranks flush/stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= ID_EX_BUBBLE;
        end else begin
            ex_q <= ex_d;
        end
    end

    fwd_unit u_fwd (
        .ex_rs_i        (ex_q.rs),
        .ex_rt_i        (ex_q.rt),
        .exm_regwrite_i (exm_regwrite),
        .exm_rd_i       (exm_rd),
        .mwb_regwrite_i (mwb_regwrite),
        .mwb_rd_i       (mwb_rd),
        .fwd_a_o        (fwd_a_sel),
        .fwd_b_o        (fwd_b_sel)
    );

    // Forwarded operand values.
    always_comb begin
        fwd_a = ex_q.rs_val;
        fwd_b = ex_q.rt_val;
        unique case (fwd_a_sel)
            FWD_EXM: fwd_a = exm_result;
            FWD_MWB: fwd_a = mwb_result;
            default: fwd_a = ex_q.rs_val;
        endcase
        unique case (fwd_b_sel)
            FWD_EXM: fwd_b = exm_result;
            FWD_MWB: fwd_b = mwb_result;
            default: fwd_b = ex_q.rt_val;
        endcase
    end

    // ALU operands, store data and destination register. An empty EX slot
    // shows ADD so the ALU never sees a stale or undefined code.
    always_comb begin
        alu_a      = fwd_a;
        alu_b      = ex_q.ctrl.alusrc ? ex_q.imm : fwd_b;
        store_data = fwd_b;
        alu_gin    = ex_q.valid ? ex_q.gin : ALU_ADD;
        ex_wr_rd   = ex_q.ctrl.regdst ? ex_q.rd : ex_q.rt;
    end

    assign ex_valid    = ex_q.valid;
    assign ex_regwrite = ex_q.ctrl.regwrite;
    assign ex_memread  = ex_q.ctrl.memread;
    assign ex_memwrite = ex_q.ctrl.memwrite;
    assign ex_memtoreg = ex_q.ctrl.memtoreg;
    assign ex_branch   = ex_q.ctrl.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a vector table for single-instruction
// behaviour plus hand-written load-use, flush and reset sequences.
module tb_id_ex_stage;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_val, id_rt_val, id_imm;
    logic [3:0]  id_gin;
    logic        id_alusrc, id_regdst, id_regwrite, id_memread;
    logic        id_memwrite, id_memtoreg, id_branch;
    logic        flush;
    logic        exm_regwrite, mwb_regwrite;
    logic [4:0]  exm_rd, mwb_rd;
    logic [31:0] exm_result, mwb_result;
    logic        stall;
    logic [31:0] alu_a, alu_b, store_data;
    logic [3:0]  alu_gin;
    logic [4:0]  ex_wr_rd;
    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite;
    logic        ex_memtoreg, ex_branch;

    id_ex_stage dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .id_rs_val    (id_rs_val),
        .id_rt_val    (id_rt_val),
        .id_imm       (id_imm),
        .id_gin       (id_gin),
        .id_alusrc    (id_alusrc),
        .id_regdst    (id_regdst),
        .id_regwrite  (id_regwrite),
        .id_memread   (id_memread),
        .id_memwrite  (id_memwrite),
        .id_memtoreg  (id_memtoreg),
        .id_branch    (id_branch),
        .flush        (flush),
        .exm_regwrite (exm_regwrite),
        .exm_rd       (exm_rd),
        .exm_result   (exm_result),
        .mwb_regwrite (mwb_regwrite),
        .mwb_rd       (mwb_rd),
        .mwb_result   (mwb_result),
        .stall        (stall),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_gin      (alu_gin),
        .store_data   (store_data),
        .ex_wr_rd     (ex_wr_rd),
        .ex_valid     (ex_valid),
        .ex_regwrite  (ex_regwrite),
        .ex_memread   (ex_memread),
        .ex_memwrite  (ex_memwrite),
        .ex_memtoreg  (ex_memtoreg),
        .ex_branch    (ex_branch)
    );

    // ---------------- vector table ----------------
    // ctl = {alusrc, regdst, regwrite, memread, memwrite, memtoreg, branch}
    // ectl = {regwrite, memread, memwrite, memtoreg, branch}
    typedef struct {
        logic        vld;
        logic [4:0]  rs;
        logic [31:0] rsv;
        logic [4:0]  rt;
        logic [31:0] rtv;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  gin;
        logic [6:0]  ctl;
        logic        fl;
        logic        erw;
        logic [4:0]  erd;
        logic [31:0] eres;
        logic        mrw;
        logic [4:0]  mrd;
        logic [31:0] mres;
        logic        chk_data;
        logic        exp_valid;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [31:0] exp_sd;
        logic [3:0]  exp_gin;
        logic [4:0]  exp_wr;
        logic [4:0]  exp_ctl;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];

    function automatic vec_t mk(
        input logic vld, input logic [4:0] rs, input logic [31:0] rsv,
        input logic [4:0] rt, input logic [31:0] rtv, input logic [4:0] rd,
        input logic [31:0] imm, input logic [3:0] gin, input logic [6:0] ctl,
        input logic fl, input logic erw, input logic [4:0] erd, input logic [31:0] eres,
        input logic mrw, input logic [4:0] mrd, input logic [31:0] mres,
        input logic cd, input logic ev, input logic [31:0] ea, input logic [31:0] eb,
        input logic [31:0] esd, input logic [3:0] eg, input logic [4:0] ew,
        input logic [4:0] ec
    );
        vec_t v;
        v.vld = vld; v.rs = rs; v.rsv = rsv; v.rt = rt; v.rtv = rtv; v.rd = rd;
        v.imm = imm; v.gin = gin; v.ctl = ctl; v.fl = fl;
        v.erw = erw; v.erd = erd; v.eres = eres;
        v.mrw = mrw; v.mrd = mrd; v.mres = mres;
        v.chk_data = cd; v.exp_valid = ev; v.exp_a = ea; v.exp_b = eb;
        v.exp_sd = esd; v.exp_gin = eg; v.exp_wr = ew; v.exp_ctl = ec;
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_id(
        input logic vld, input logic [4:0] rs, input logic [31:0] rsv,
        input logic [4:0] rt, input logic [31:0] rtv, input logic [4:0] rd,
        input logic [31:0] imm, input logic [3:0] gin, input logic [6:0] ctl
    );
        id_valid  = vld;
        id_rs     = rs;
        id_rs_val = rsv;
        id_rt     = rt;
        id_rt_val = rtv;
        id_rd     = rd;
        id_imm    = imm;
        id_gin    = gin;
        {id_alusrc, id_regdst, id_regwrite, id_memread,
         id_memwrite, id_memtoreg, id_branch} = ctl;
    endtask

    task automatic set_fwd(
        input logic erw, input logic [4:0] erd, input logic [31:0] eres,
        input logic mrw, input logic [4:0] mrd, input logic [31:0] mres
    );
        exm_regwrite = erw;
        exm_rd       = erd;
        exm_result   = eres;
        mwb_regwrite = mrw;
        mwb_rd       = mrd;
        mwb_result   = mres;
    endtask

    function automatic logic [4:0] ex_ctl();
        return {ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch};
    endfunction

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // ---------------- test ----------------
    initial begin
        //                vld rs rsv           rt rtv           rd imm            gin    ctl         fl erw erd eres          mrw mrd mres          cd ev exp_a         exp_b         exp_sd        eg     ew  ectl
        vecs[0]  = mk(1, 1, 32'd5,        2, 32'd7,        4, 32'd0,        4'h2, 7'b0110000, 0, 0, 0,  32'd0,        0, 0,  32'd0,        1, 1, 32'd5,        32'd7,        32'd7,        4'h2, 4,  5'b10000);
        vecs[1]  = mk(1, 1, 32'd5,        2, 32'd7,        6, 32'd0,        4'h6, 7'b0110000, 0, 1, 1,  32'd100,      1, 1,  32'd200,      1, 1, 32'd100,      32'd7,        32'd7,        4'h6, 6,  5'b10000);
        vecs[2]  = mk(1, 3, 32'd10,       5, 32'd20,       7, 32'd0,        4'h1, 7'b0110000, 0, 1, 9,  32'h999,      1, 5,  32'h55,       1, 1, 32'd10,       32'h55,       32'h55,       4'h1, 7,  5'b10000);
        vecs[3]  = mk(1, 2, 32'd8,        9, 32'h33,       0, 32'hFFFFFFFC, 4'h2, 7'b1010000, 0, 1, 9,  32'h77,       0, 0,  32'd0,        1, 1, 32'd8,        32'hFFFFFFFC, 32'h77,       4'h2, 9,  5'b10000);
        vecs[4]  = mk(1, 0, 32'd0,        0, 32'h11,       8, 32'd0,        4'h7, 7'b0110000, 0, 1, 0,  32'hDEAD,     1, 0,  32'hBEEF,     1, 1, 32'd0,        32'h11,       32'h11,       4'h7, 8,  5'b10000);
        vecs[5]  = mk(1, 4, 32'h40,       6, 32'h60,       1, 32'd0,        4'h0, 7'b0000001, 0, 0, 4,  32'd1,        0, 6,  32'd2,        1, 1, 32'h40,       32'h60,       32'h60,       4'h0, 6,  5'b00001);
        vecs[6]  = mk(1, 10, 32'h1000,    11, 32'hCAFE,    0, 32'd4,        4'h2, 7'b1000100, 0, 0, 0,  32'd0,        1, 11, 32'hF00D,     1, 1, 32'h1000,     32'd4,        32'hF00D,     4'h2, 11, 5'b00100);
        vecs[7]  = mk(1, 10, 32'h2000,    12, 32'd0,       0, 32'd8,        4'h2, 7'b1011010, 0, 1, 10, 32'h3000,     0, 0,  32'd0,        1, 1, 32'h3000,     32'd8,        32'd0,        4'h2, 12, 5'b11010);
        vecs[8]  = mk(1, 13, 32'd3,       12, 32'h99,      0, 32'h10,       4'h2, 7'b1010000, 0, 0, 0,  32'd0,        0, 0,  32'd0,        1, 1, 32'd3,        32'h10,       32'h99,       4'h2, 12, 5'b10000);
        vecs[9]  = mk(1, 1, 32'd5,        2, 32'd7,        4, 32'd0,        4'h6, 7'b0110000, 1, 0, 0,  32'd0,        0, 0,  32'd0,        0, 0, 32'd0,        32'd0,        32'd0,        4'h2, 0,  5'b00000);
        vecs[10] = mk(1, 7, 32'h70,       8, 32'h80,       9, 32'd0,        4'hC, 7'b0110000, 0, 1, 8,  32'hA,        1, 8,  32'hB,        1, 1, 32'h70,       32'hA,        32'hA,        4'hC, 9,  5'b10000);
        vecs[11] = mk(0, 1, 32'd1,        2, 32'd2,        3, 32'd0,        4'hF, 7'b0000000, 0, 0, 0,  32'd0,        0, 0,  32'd0,        0, 0, 32'd0,        32'd0,        32'd0,        4'h2, 0,  5'b00000);
        vecs[12] = mk(1, 3, 32'h30,       4, 32'h40,       5, 32'd0,        4'hF, 7'b0110000, 0, 0, 0,  32'd0,        0, 0,  32'd0,        1, 1, 32'h30,       32'h40,       32'h40,       4'hF, 5,  5'b10000);

        // reset with idle inputs
        reset = 1'b1;
        flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 4'h0, 7'b0);
        set_fwd(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst ex_valid", 32'(ex_valid), 32'd0);
        chk("rst alu_gin", 32'(alu_gin), 32'h2);
        chk("rst ex_wr_rd", 32'(ex_wr_rd), 32'd0);
        chk("rst ctl", 32'(ex_ctl()), 32'd0);
        chk("rst alu_a", alu_a, 32'd0);
        chk("rst alu_b", alu_b, 32'd0);
        chk("rst store", store_data, 32'd0);
        chk("rst stall", 32'(stall), 32'd0);

        // table vectors: ID in one cycle, EX outputs the next
        for (int i = 0; i < NV; i++) begin
            vec_t v;
            logic [31:0] ea;
            v = vecs[i];
            set_id(v.vld, v.rs, v.rsv, v.rt, v.rtv, v.rd, v.imm, v.gin, v.ctl);
            flush = v.fl;
            set_fwd(0, 0, 0, 0, 0, 0);
            exp_q.push_back(v.exp_a);
            #3;
            chk($sformatf("v%0d stall", i), 32'(stall), 32'd0);
            @(posedge clk);
            #1;
            id_valid = 1'b0;
            flush    = 1'b0;
            set_fwd(v.erw, v.erd, v.eres, v.mrw, v.mrd, v.mres);
            #1;
            ea = exp_q.pop_front();
            chk($sformatf("v%0d ex_valid", i), 32'(ex_valid), 32'(v.exp_valid));
            chk($sformatf("v%0d alu_gin", i), 32'(alu_gin), 32'(v.exp_gin));
            chk($sformatf("v%0d ctl", i), 32'(ex_ctl()), 32'(v.exp_ctl));
            if (v.chk_data) begin
                chk($sformatf("v%0d alu_a", i), alu_a, ea);
                chk($sformatf("v%0d alu_b", i), alu_b, v.exp_b);
                chk($sformatf("v%0d store", i), store_data, v.exp_sd);
                chk($sformatf("v%0d ex_wr_rd", i), 32'(ex_wr_rd), 32'(v.exp_wr));
            end
        end

        // load-use on rs: one stall cycle, bubble, then forwarded from MEM/WB
        set_id(1, 1, 32'h100, 3, 32'd0, 0, 32'd0, 4'h2, 7'b1011010);
        set_fwd(0, 0, 0, 0, 0, 0);
        #3;
        chk("lw stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        set_id(0, 3, 32'd0, 4, 32'd4, 5, 32'd0, 4'h2, 7'b0110000);
        #1;
        chk("lu idle stall", 32'(stall), 32'd0);
        id_valid = 1'b1;
        #1;
        chk("lu stall", 32'(stall), 32'd1);
        chk("lu ex_memread", 32'(ex_memread), 32'd1);
        @(posedge clk);
        #1;
        chk("lu bubble valid", 32'(ex_valid), 32'd0);
        chk("lu bubble ctl", 32'(ex_ctl()), 32'd0);
        chk("lu stall released", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        set_fwd(0, 0, 0, 1, 3, 32'hABC);
        #1;
        chk("lu ex_valid", 32'(ex_valid), 32'd1);
        chk("lu alu_a", alu_a, 32'hABC);
        chk("lu alu_b", alu_b, 32'd4);
        chk("lu ex_wr_rd", 32'(ex_wr_rd), 32'd5);

        // store-data hazard on rt with flush in the same cycle
        set_id(1, 1, 32'h100, 6, 32'd0, 0, 32'd0, 4'h2, 7'b1011010);
        set_fwd(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        set_id(1, 2, 32'h20, 6, 32'd6, 0, 32'd4, 4'h2, 7'b1000100);
        #1;
        chk("sw stall", 32'(stall), 32'd1);
        flush = 1'b1;
        #1;
        chk("sw stall flush", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("fl bubble valid", 32'(ex_valid), 32'd0);
        chk("fl bubble memwrite", 32'(ex_memwrite), 32'd0);
        chk("fl alu_gin", 32'(alu_gin), 32'h2);
        chk("fl stall", 32'(stall), 32'd0);

        // a load into $0 never stalls
        set_id(1, 1, 32'h100, 0, 32'd0, 0, 32'd0, 4'h2, 7'b1011010);
        @(posedge clk);
        #1;
        set_id(1, 0, 32'd0, 0, 32'd0, 2, 32'd0, 4'h2, 7'b0110000);
        #1;
        chk("rt0 stall", 32'(stall), 32'd0);

        // reset with a valid load in EX and a dependent instruction in ID
        set_id(1, 1, 32'h100, 7, 32'd0, 0, 32'd0, 4'h6, 7'b1011010);
        @(posedge clk);
        #1;
        chk("pre-rst ex_valid", 32'(ex_valid), 32'd1);
        chk("pre-rst alu_gin", 32'(alu_gin), 32'h6);
        set_id(1, 7, 32'd0, 8, 32'd8, 9, 32'd0, 4'h2, 7'b0110000);
        #1;
        chk("pre-rst stall", 32'(stall), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mid-rst ex_valid", 32'(ex_valid), 32'd0);
        chk("mid-rst ctl", 32'(ex_ctl()), 32'd0);
        chk("mid-rst alu_gin", 32'(alu_gin), 32'h2);
        chk("mid-rst ex_wr_rd", 32'(ex_wr_rd), 32'd0);
        chk("mid-rst alu_a", alu_a, 32'd0);
        chk("mid-rst stall", 32'(stall), 32'd0);

        // ---------------- report ----------------
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
